nexusv_bus_arbiter: RTL
=======================

// Module: nexusv_bus_arbiter
// PURPOSE
//  Two-master arbiter/sequencer for the single nexusV_core system bus. Shares the one
//  bus_* port between instruction fetch (F) and load/store (D) requesters.
//  Data priority with an anti-starvation guard for fetch.
//  Bus watchdog: aborts a hung transfer and returns an error flag for access-fault traps.
// PARAMETERS
//  XLEN          32  address/data width
//  TIMEOUT       16  max cycles bus_valid is held without bus_ready; 0 = watchdog disabled
//  MAX_D_STREAK   4  consecutive D grants while F waits before F is forced; >=1
// PORTS
//  clk        in   1     clock, all state on posedge
//  rst        in   1     asynchronous, active-high reset
//  f_req      in   1     fetch request; held high until f_done
//  f_addr     in   XLEN  fetch address, stable while f_req
//  f_done     out  1     1-cycle pulse: fetch transfer finished
//  f_rdata    out  XLEN  fetch read data, valid with f_done (0 if f_err)
//  f_err      out  1     with f_done: transfer timed out
//  d_req      in   1     load/store request; held high until d_done
//  d_addr     in   XLEN  data address
//  d_wdata    in   XLEN  store data
//  d_write    in   1     1 = store, 0 = load
//  d_done     out  1     1-cycle pulse: data transfer finished
//  d_rdata    out  XLEN  load data, valid with d_done (0 on store or error)
//  d_err      out  1     with d_done: transfer timed out
//  bus_addr   out  XLEN  bus address
//  bus_wdata  out  XLEN  bus write data
//  bus_write  out  1     bus write strobe
//  bus_valid  out  1     bus transfer request
//  bus_rdata  in   XLEN  bus read data, sampled when bus_valid & bus_ready
//  bus_ready  in   1     slave completes transfer this cycle
//  busy       out  1     arbiter owns bus (state != IDLE)
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; streak=0; wdog=0. Asserting rst mid-transfer drops
//    bus_valid immediately; no done pulse is generated for the killed transfer.
//  FSM: IDLE, BUSY_F, BUSY_D.
//  IDLE: arbitrate at posedge. Winner's addr/wdata/write latched into bus_* regs.
//    only F -> BUSY_F; only D -> BUSY_D;
//    both -> BUSY_D unless streak==MAX_D_STREAK, then BUSY_F. Neither -> stay.
//  Streak: on D grant with f_req=1 -> streak+1 (saturates); on D grant with f_req=0 or
//    any F grant -> 0.
//  BUSY_x: bus_valid=1, bus_* held constant. wdog cleared on entry, +1 each cycle
//    bus_ready=0.
//    bus_ready=1 -> capture bus_rdata (0 for stores); next cycle x_done=1, x_err=0; -> IDLE.
//    TIMEOUT!=0 and bus_ready=0 and wdog==TIMEOUT-1 -> next cycle x_done=1, x_err=1,
//      x_rdata=0; bus_valid=0; -> IDLE. bus_valid is therefore high for exactly TIMEOUT
//      cycles.
//    bus_ready=1 in the timeout cycle: the completion wins, err=0.
//  Latency: req seen at edge N -> bus_valid from N+1. If ready at N+1, done is at N+2.
//    The IDLE cycle on the done cycle arbitrates again: next bus_valid earliest N+3.
//  Outputs are registered. x_done, x_err and x_rdata hold 0 except during the done pulse.
//    bus_write=0 whenever bus_valid=0.
//  Requester dropping req while granted is illegal and is ignored: the transfer completes
//    and done still pulses.
//  Never grants both requesters; at most one transfer outstanding.
// TESTING
//  1 Fetch only: f_req, f_addr=0x100, bus_ready tied 1, bus_rdata=0x00500093.
//    -> bus_valid 1 cycle, addr 0x100; f_done next cycle, f_rdata=0x00500093, f_err=0.
//  2 Simultaneous: f_req & d_req, d_write=1, d_addr=0x2000, d_wdata=0xDEADBEEF.
//    -> D served first with bus_write=1; then F; d_rdata=0.
//  3 Starvation: d_req held continuously (MAX_D_STREAK=4) with f_req high.
//    -> 4 D grants, then 1 F grant, then D again.
//  4 Timeout: bus_ready=0 forever, TIMEOUT=16, load.
//    -> bus_valid high 16 cycles; d_done & d_err next cycle; d_rdata=0; busy=0 after.
//  5 Race: bus_ready rises exactly in the 16th wait cycle.
//    -> d_err=0, d_rdata=bus_rdata.
//  6 Reset mid-transfer: rst high while BUSY_D.
//    -> bus_valid=0 asynchronously, no d_done; after release an F request is served
//       normally.

Source files
------------

// File: rtl/nexusv_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : nexusv_bus_arbiter_if
// Brief    : nexusV system bus signal bundle; master = arbiter, slave = memory.
// Revision : 1.0
// ============================================================================
interface nexusv_bus_arbiter_if #(
    parameter int XLEN = 32
) ();
    logic [XLEN-1:0] bus_addr;
    logic [XLEN-1:0] bus_wdata;
    logic            bus_write;
    logic            bus_valid;
    logic [XLEN-1:0] bus_rdata;
    logic            bus_ready;

    modport master (
        output bus_addr,
        output bus_wdata,
        output bus_write,
        output bus_valid,
        input  bus_rdata,
        input  bus_ready
    );

    modport slave (
        input  bus_addr,
        input  bus_wdata,
        input  bus_write,
        input  bus_valid,
        output bus_rdata,
        output bus_ready
    );
endinterface
`default_nettype wire

// File: rtl/nexusv_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : nexusv_bus_arbiter
// Brief    : Fetch/data bus arbiter with fetch anti-starvation and bus watchdog.
// Revision : 1.0
// ============================================================================
module nexusv_bus_arbiter #(
    parameter int XLEN         = 32,
    parameter int TIMEOUT      = 16,
    parameter int MAX_D_STREAK = 4
) (
    input  wire                  clk,
    input  wire                  rst,
    input  wire                  f_req,
    input  wire  [XLEN-1:0]      f_addr,
    output logic                 f_done,
    output logic [XLEN-1:0]      f_rdata,
    output logic                 f_err,
    input  wire                  d_req,
    input  wire  [XLEN-1:0]      d_addr,
    input  wire  [XLEN-1:0]      d_wdata,
    input  wire                  d_write,
    output logic                 d_done,
    output logic [XLEN-1:0]      d_rdata,
    output logic                 d_err,
    nexusv_bus_arbiter_if.master bus,
    output logic                 busy
);

    localparam int STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);
    localparam logic [WD_W-1:0]     WD_LAST    = WD_W'(TIMEOUT - 1);
    localparam bit                  WDOG_EN    = (TIMEOUT != 0);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_F = 2'd1,
        BUSY_D = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [XLEN-1:0]       addr_q;
    logic [XLEN-1:0]       wdata_q;
    logic                  write_q;
    logic [STREAK_W-1:0]   streak;
    logic [WD_W-1:0]       wdog;
    logic                  grant_f;
    logic                  grant_d;
    logic                  finish;
    logic                  abort;

    always_comb begin
        state_nxt = state;
        grant_f   = 1'b0;
        grant_d   = 1'b0;
        finish    = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                // Data wins unless fetch has already waited out a full streak.
                if (d_req && !(f_req && (streak == STREAK_MAX))) begin
                    grant_d   = 1'b1;
                    state_nxt = BUSY_D;
                end else if (f_req) begin
                    grant_f   = 1'b1;
                    state_nxt = BUSY_F;
                end
            end
            BUSY_F, BUSY_D: begin
                if (bus.bus_ready) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end else if (WDOG_EN && (wdog == WD_LAST)) begin
                    abort     = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            streak  <= '0;
            wdog    <= '0;
            f_done  <= 1'b0;
            f_err   <= 1'b0;
            f_rdata <= '0;
            d_done  <= 1'b0;
            d_err   <= 1'b0;
            d_rdata <= '0;
        end else begin
            state   <= state_nxt;
            f_done  <= 1'b0;
            f_err   <= 1'b0;
            f_rdata <= '0;
            d_done  <= 1'b0;
            d_err   <= 1'b0;
            d_rdata <= '0;

            if (grant_d) begin
                addr_q  <= d_addr;
                wdata_q <= d_wdata;
                write_q <= d_write;
                wdog    <= '0;
                if (!f_req) begin
                    streak <= '0;
                end else if (streak != STREAK_MAX) begin
                    streak <= streak + 1'b1;
                end
            end

            if (grant_f) begin
                addr_q  <= f_addr;
                wdata_q <= '0;
                write_q <= 1'b0;
                wdog    <= '0;
                streak  <= '0;
            end

            if ((state != IDLE) && !bus.bus_ready) begin
                wdog <= wdog + 1'b1;
            end

            // Results are zero on timeout; store completions return zero data.
            if (finish || abort) begin
                write_q <= 1'b0;
                if (state == BUSY_F) begin
                    f_done  <= 1'b1;
                    f_err   <= abort;
                    f_rdata <= finish ? bus.bus_rdata : '0;
                end else begin
                    d_done  <= 1'b1;
                    d_err   <= abort;
                    d_rdata <= (finish && !write_q) ? bus.bus_rdata : '0;
                end
            end
        end
    end

    assign bus.bus_valid = (state != IDLE);
    assign bus.bus_addr  = addr_q;
    assign bus.bus_wdata = wdata_q;
    assign bus.bus_write = write_q;
    assign busy          = (state != IDLE);

endmodule
`default_nettype wire
